servo_door_scheduler: RTL and testbench

- Sequencing controller for the servo PWM generator.
- Arbitrates door open/close requests from the presence sensor, manual buttons and a lock input.
- Produces a slew-limited duty command (in clock cycles), updated once per 20 ms servo frame, so the servo ramps between the closed and open positions instead of jumping.
- Adds auto-close after a hold time and reopens if presence reappears while closing.

---
 rtl/servo_door_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_servo_door_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/servo_door_scheduler.sv
// Door servo sequencer: arbitrates open/close requests and ramps the PWM duty
// command by one slew step per servo frame between the closed and open positions.
module servo_door_scheduler #(
  parameter int unsigned FRAME_CYCLES = 1_000_000,
  parameter int unsigned MIN_DUTY     = 50_000,
  parameter int unsigned MAX_DUTY     = 100_000,
  parameter int unsigned STEP         = 2_500,
  parameter int unsigned HOLD_CYCLES  = 125_000_000,
  parameter int unsigned DUTY_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              open_req,
  input  logic              manual_open,
  input  logic              manual_close,
  input  logic              lock,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        state,
  output logic              door_open,
  output logic              moving
);

  localparam logic [1:0] ST_CLOSED  = 2'd0;
  localparam logic [1:0] ST_OPENING = 2'd1;
  localparam logic [1:0] ST_OPEN    = 2'd2;
  localparam logic [1:0] ST_CLOSING = 2'd3;

  localparam int unsigned DX_W    = DUTY_W + 1;
  localparam int unsigned FRAME_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_ZERO = FRAME_W'(0);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_ZERO  = HOLD_W'(0);
  localparam logic [DUTY_W-1:0]  MIN_D      = DUTY_W'(MIN_DUTY);
  localparam logic [DUTY_W-1:0]  MAX_D      = DUTY_W'(MAX_DUTY);
  localparam logic [DX_W-1:0]    MIN_X      = DX_W'(MIN_DUTY);
  localparam logic [DX_W-1:0]    MAX_X      = DX_W'(MAX_DUTY);
  localparam logic [DX_W-1:0]    STEP_X     = DX_W'(STEP);

  // One extra bit keeps the sum from wrapping before the clamp is applied.
  function automatic logic [DUTY_W-1:0] step_up(input logic [DUTY_W-1:0] d);
    logic [DX_W-1:0] sum;
    sum = {1'b0, d} + STEP_X;
    if (sum > MAX_X) begin
      step_up = MAX_D;
    end else begin
      step_up = sum[DUTY_W-1:0];
    end
  endfunction

  // A borrow shows up in the top bit and is clamped like any undershoot.
  function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] d);
    logic [DX_W-1:0] diff;
    diff = {1'b0, d} - STEP_X;
    if (diff[DUTY_W] || (diff < MIN_X)) begin
      step_down = MIN_D;
    end else begin
      step_down = diff[DUTY_W-1:0];
    end
  endfunction

  logic [FRAME_W-1:0] frame_cnt_r;
  logic [HOLD_W-1:0]  hold_r;
  logic [HOLD_W-1:0]  hold_nxt_s;
  logic [DUTY_W-1:0]  duty_r;
  logic [DUTY_W-1:0]  duty_nxt_s;
  logic [DUTY_W-1:0]  up_s;
  logic [DUTY_W-1:0]  down_s;
  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic               door_open_r;
  logic               moving_r;
  logic               frame_tick_s;
  logic               open_evt_s;
  logic               close_evt_s;

  assign frame_tick_s = (frame_cnt_r == FRAME_LAST);
  assign up_s         = step_up(duty_r);
  assign down_s       = step_down(duty_r);
  assign close_evt_s  = lock | manual_close;
  assign open_evt_s   = ~lock & ~manual_close & (open_req | manual_open);

  // Free-running servo frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= FRAME_ZERO;
    end else if (frame_tick_s) begin
      frame_cnt_r <= FRAME_ZERO;
    end else begin
      frame_cnt_r <= frame_cnt_r + FRAME_ONE;
    end
  end

  // Next duty: stepping follows the state held before the edge, so a state
  // entered on a tick edge does not step on that edge.
  always_comb begin
    duty_nxt_s = duty_r;
    if (frame_tick_s) begin
      case (state_r)
        ST_OPENING: duty_nxt_s = up_s;
        ST_CLOSING: duty_nxt_s = down_s;
        ST_OPEN:    duty_nxt_s = MAX_D;
        ST_CLOSED:  duty_nxt_s = MIN_D;
        default:    duty_nxt_s = MIN_D;
      endcase
    end else begin
      duty_nxt_s = duty_r;
    end
  end

  // Request arbitration and hold timing; lock and close always beat an open.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = HOLD_ZERO;
    case (state_r)
      ST_CLOSED: begin
        if (open_evt_s) begin
          state_nxt_s = ST_OPENING;
        end else begin
          state_nxt_s = ST_CLOSED;
        end
      end
      ST_OPENING: begin
        if (close_evt_s) begin
          state_nxt_s = ST_CLOSING;
        end else if (frame_tick_s && (up_s == MAX_D)) begin
          state_nxt_s = ST_OPEN;
        end else begin
          state_nxt_s = ST_OPENING;
        end
      end
      ST_OPEN: begin
        if (close_evt_s) begin
          state_nxt_s = ST_CLOSING;
        end else if (open_req || manual_open) begin
          state_nxt_s = ST_OPEN;
          hold_nxt_s  = HOLD_ZERO;
        end else if (hold_r == HOLD_LAST) begin
          state_nxt_s = ST_CLOSING;
        end else begin
          state_nxt_s = ST_OPEN;
          hold_nxt_s  = hold_r + HOLD_ONE;
        end
      end
      ST_CLOSING: begin
        if (open_evt_s) begin
          state_nxt_s = ST_OPENING;
        end else if (frame_tick_s && (down_s == MIN_D)) begin
          state_nxt_s = ST_CLOSED;
        end else begin
          state_nxt_s = ST_CLOSING;
        end
      end
      default: begin
        state_nxt_s = ST_CLOSED;
      end
    endcase
  end

  // State, duty and decoded status flags all update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_CLOSED;
      duty_r      <= MIN_D;
      hold_r      <= HOLD_ZERO;
      door_open_r <= 1'b0;
      moving_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      duty_r      <= duty_nxt_s;
      hold_r      <= hold_nxt_s;
      door_open_r <= (state_nxt_s == ST_OPEN);
      moving_r    <= (state_nxt_s == ST_OPENING) || (state_nxt_s == ST_CLOSING);
    end
  end

  assign duty      = duty_r;
  assign state     = state_r;
  assign door_open = door_open_r;
  assign moving    = moving_r;

endmodule

// File: tb/tb_servo_door_scheduler.sv
// Directed bench for servo_door_scheduler with a 10-cycle frame; frame ticks
// land on every tenth rising edge counted from reset release.
module tb_servo_door_scheduler;

  localparam int unsigned DUTY_W = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              open_req = 1'b0;
  logic              manual_open = 1'b0;
  logic              manual_close = 1'b0;
  logic              lock = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic [1:0]        state;
  logic              door_open;
  logic              moving;

  int chk_cnt = 0;
  int err_cnt = 0;

  servo_door_scheduler #(
    .FRAME_CYCLES(10),
    .MIN_DUTY    (50),
    .MAX_DUTY    (100),
    .STEP        (20),
    .HOLD_CYCLES (30),
    .DUTY_W      (DUTY_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .open_req    (open_req),
    .manual_open (manual_open),
    .manual_close(manual_close),
    .lock        (lock),
    .duty        (duty),
    .state       (state),
    .door_open   (door_open),
    .moving      (moving)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int d, input int s, input int o, input int m);
    chk({tag, ".duty"},  32'(duty),      32'(d));
    chk({tag, ".state"}, 32'(state),     32'(s));
    chk({tag, ".open"},  32'(door_open), 32'(o));
    chk({tag, ".mov"},   32'(moving),    32'(m));
  endtask

  initial begin
    tick(2);
    chk_all("reset", 50, 0, 0, 0);
    open_req = 1'b1;
    rst      = 1'b0;

    // 1: open ramp, ticks at E10/E20/E30
    tick(1);  chk_all("ramp_e1", 50, 1, 0, 1);
    tick(8);  chk("ramp_midframe", 32'(duty), 32'd50);
    tick(1);  chk("ramp_e10", 32'(duty), 32'd70);
    tick(10); chk_all("ramp_e20", 90, 1, 0, 1);
    tick(10); chk_all("ramp_e30", 100, 2, 1, 0);

    // 2: auto-close 30 cycles after open_req drops
    open_req = 1'b0;
    tick(29); chk("hold_e59", 32'(state), 32'd2);
    tick(1);  chk_all("hold_e60", 100, 3, 0, 1);
    tick(10); chk("close_e70", 32'(duty), 32'd80);
    tick(10); chk("close_e80", 32'(duty), 32'd60);
    tick(10); chk_all("close_e90", 50, 0, 0, 0);

    // 3: safety reopen from duty 80
    open_req = 1'b1;
    tick(1);  chk("reopen_setup_e91", 32'(state), 32'd1);
    tick(29); chk("reopen_setup_e120", 32'(state), 32'd2);
    open_req = 1'b0;
    tick(30); chk_all("reopen_e150", 100, 3, 0, 1);
    tick(10); chk("reopen_e160", 32'(duty), 32'd80);
    open_req = 1'b1;
    tick(1);  chk_all("reopen_e161", 80, 1, 0, 1);
    tick(9);  chk_all("reopen_e170", 100, 2, 1, 0);

    // 4: lock, lock-blocked open, simultaneous pulses
    open_req = 1'b0;
    lock     = 1'b1;
    tick(1);  chk("lock_open_e171", 32'(state), 32'd3);
    tick(29); chk_all("lock_e200", 50, 0, 0, 0);
    lock     = 1'b0;
    open_req = 1'b1;
    tick(1);  chk("lock_e201", 32'(state), 32'd1);
    tick(9);  chk("lock_e210", 32'(duty), 32'd70);
    tick(3);
    lock = 1'b1;
    tick(1);  chk_all("lock_e214", 70, 3, 0, 1);
    tick(6);  chk_all("lock_e220", 50, 0, 0, 0);
    open_req    = 1'b0;
    manual_open = 1'b1;
    tick(1);  chk("lock_blocks_open", 32'(state), 32'd0);
    manual_open = 1'b0;
    lock        = 1'b0;
    open_req    = 1'b1;
    tick(1);  chk("pulse_e222", 32'(state), 32'd1);
    tick(28); chk_all("pulse_e250", 100, 2, 1, 0);
    open_req     = 1'b0;
    manual_open  = 1'b1;
    manual_close = 1'b1;
    tick(1);  chk_all("both_pulses", 100, 3, 0, 1);
    manual_open  = 1'b0;
    manual_close = 1'b0;
    tick(29); chk("pulse_e280", 32'(state), 32'd0);

    // 5: manual_open restarts the hold timer
    open_req = 1'b1;
    tick(1);
    tick(29); chk("restart_e310", 32'(state), 32'd2);
    open_req = 1'b0;
    tick(20); chk("restart_e330", 32'(state), 32'd2);
    manual_open = 1'b1;
    tick(1);
    manual_open = 1'b0;
    tick(9);  chk("restart_e340", 32'(state), 32'd2);
    tick(20); chk("restart_e360", 32'(state), 32'd2);
    tick(1);  chk_all("restart_e361", 100, 3, 0, 1);

    // 6: async reset mid-ramp
    tick(29); chk("arst_e390", 32'(state), 32'd0);
    open_req = 1'b1;
    tick(1);
    tick(19); chk_all("arst_e410", 90, 1, 0, 1);
    tick(2);
    #3;
    rst = 1'b1;
    #1;
    chk_all("arst_now", 50, 0, 0, 0);
    open_req = 1'b0;
    #2;
    rst = 1'b0;
    tick(25); chk_all("arst_after", 50, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
